// File: rtl/core_host_pkg.sv
// Shared types for the host-side run sequencer: state encoding, default widths
// and a small constant helper used to size the shared byte counter.
package core_host_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DRAIN,
    FINISH
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/core_host_seq.sv
// Host run sequencer: loads input bytes into data memory, runs the core, then drains results.
// Optional RUN watchdog and sticky timeout output when CORE_HOST_TIMEOUT_EN is defined.
module core_host_seq
  import core_host_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LOAD_BASE   = 0,
  parameter int LOAD_LEN    = 64,
  parameter int RESULT_BASE = 64,
  parameter int RESULT_LEN  = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_own,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_start,
  input  logic              core_done,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              seq_done
`ifdef CORE_HOST_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  localparam int CNT_W = $clog2(max_int(LOAD_LEN, RESULT_LEN) + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_LEN - 1);
  localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'(RESULT_LEN - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_first_q;
  logic             in_ready_q, mem_own_q, out_valid_q, busy_q, seq_done_q, core_start_q;
  logic             done_ok, run_limit;

  // A done level seen in the first RUN cycle is left over from the previous run.
  assign done_ok = !run_first_q && core_done;

`ifdef CORE_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] run_cnt_q;
  logic            timeout_q;

  assign run_limit = (run_cnt_q == TO_LAST);
  assign timeout   = timeout_q;
`else
  localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
  assign run_limit = 1'b0;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch below sees the values from the start of the cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      run_first_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      mem_own_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      seq_done_q   <= 1'b0;
      core_start_q <= 1'b1;
`ifdef CORE_HOST_TIMEOUT_EN
      run_cnt_q    <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      seq_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            mem_own_q  <= 1'b1;
            in_ready_q <= 1'b1;
`ifdef CORE_HOST_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (cnt_q == LOAD_LAST) begin
              state_q    <= START;
              cnt_q      <= '0;
              mem_own_q  <= 1'b0;
              in_ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        START: begin
          state_q      <= RUN;
          core_start_q <= 1'b0;
          run_first_q  <= 1'b1;
`ifdef CORE_HOST_TIMEOUT_EN
          run_cnt_q    <= '0;
`endif
        end
        RUN: begin
          run_first_q <= 1'b0;
          if (done_ok || run_limit) begin
            state_q     <= DRAIN;
            cnt_q       <= '0;
            mem_own_q   <= 1'b1;
            out_valid_q <= 1'b1;
`ifdef CORE_HOST_TIMEOUT_EN
            if (!done_ok) timeout_q <= 1'b1;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
`endif
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (cnt_q == RESULT_LAST) begin
              state_q     <= FINISH;
              cnt_q       <= '0;
              mem_own_q   <= 1'b0;
              out_valid_q <= 1'b0;
              seq_done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        FINISH: begin
          state_q      <= IDLE;
          core_start_q <= 1'b1;
          busy_q       <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_own    = mem_own_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign seq_done   = seq_done_q;
  assign core_start = core_start_q;

  // The address is valid only while the port is owned; it idles at zero otherwise.
  assign mem_addr  = in_ready_q  ? ADDR_W'(LOAD_BASE)   + ADDR_W'(cnt_q) :
                     out_valid_q ? ADDR_W'(RESULT_BASE) + ADDR_W'(cnt_q) : '0;
  assign mem_we    = in_ready_q & in_valid;
  assign mem_wdata = in_ready_q ? in_data : '0;
  assign mem_re    = out_valid_q;
  assign out_data  = out_valid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_core_host_seq.sv
// Self-checking bench for core_host_seq: cycle table, randomized sequences against a
// transaction-level model, reset abort and (with CORE_HOST_TIMEOUT_EN) the RUN watchdog.
module tb_core_host_seq;

  localparam int LEN = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       go, in_valid, core_done, out_ready;
  logic [7:0] in_data;

  logic       in_ready0, mem_own0, mem_we0, mem_re0, core_start0, out_valid0, busy0, seq_done0;
  logic [7:0] mem_addr0, mem_wdata0, mem_rdata0, out_data0;
  logic       in_ready1, mem_own1, mem_we1, mem_re1, core_start1, out_valid1, busy1, seq_done1;
  logic [7:0] mem_addr1, mem_wdata1, mem_rdata1, out_data1;
`ifdef CORE_HOST_TIMEOUT_EN
  logic       timeout0, timeout1;
`endif

  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];

  assign mem_rdata0 = mem0[mem_addr0];
  assign mem_rdata1 = mem1[mem_addr1];

  always #5 clk = ~clk;

  core_host_seq #(.ADDR_W(8), .DATA_W(8), .LOAD_BASE(0), .LOAD_LEN(LEN),
                  .RESULT_BASE(64), .RESULT_LEN(LEN), .TIMEOUT_CYC(10)) dut0 (
    .clk(clk), .reset(reset), .go(go), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .mem_own(mem_own0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_we(mem_we0), .mem_re(mem_re0), .mem_rdata(mem_rdata0), .core_start(core_start0),
    .core_done(core_done), .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .busy(busy0), .seq_done(seq_done0)
`ifdef CORE_HOST_TIMEOUT_EN
    , .timeout(timeout0)
`endif
  );

  core_host_seq #(.ADDR_W(8), .DATA_W(8), .LOAD_BASE(254), .LOAD_LEN(LEN),
                  .RESULT_BASE(64), .RESULT_LEN(LEN), .TIMEOUT_CYC(10)) dut1 (
    .clk(clk), .reset(reset), .go(go), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .mem_own(mem_own1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_we(mem_we1), .mem_re(mem_re1), .mem_rdata(mem_rdata1), .core_start(core_start1),
    .core_done(core_done), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .busy(busy1), .seq_done(seq_done1)
`ifdef CORE_HOST_TIMEOUT_EN
    , .timeout(timeout1)
`endif
  );

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;

  logic [15:0] wq0[$];
  logic [15:0] wq1[$];
  logic [7:0]  oq0[$];
  logic [7:0]  oq1[$];

  logic       pend_we0, pend_we1;
  logic [7:0] pend_a0, pend_d0, pend_a1, pend_d1;

  typedef struct {
    logic       go, iv;
    logic [7:0] id;
    logic       cd, ordy;
    logic       busy, own;
    int         cs;        // 2 = not compared
    logic       ir, we;
    logic [7:0] addr;
    logic       ov;
    logic [7:0] od;
    logic       sd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic row(input logic g, input logic iv, input logic [7:0] id, input logic cd,
                     input logic ordy, input logic b, input logic own, input int cs,
                     input logic ir, input logic we, input logic [7:0] addr, input logic ov,
                     input logic [7:0] od, input logic sd);
    vec_t v;
    v.go = g; v.iv = iv; v.id = id; v.cd = cd; v.ordy = ordy;
    v.busy = b; v.own = own; v.cs = cs; v.ir = ir; v.we = we;
    v.addr = addr; v.ov = ov; v.od = od; v.sd = sd;
    tbl.push_back(v);
  endtask

  // Called at a negedge after inputs are applied: lets outputs settle and logs transfers.
  task automatic settle();
    #1;
    pend_we0 = mem_we0; pend_a0 = mem_addr0; pend_d0 = mem_wdata0;
    pend_we1 = mem_we1; pend_a1 = mem_addr1; pend_d1 = mem_wdata1;
    if (mem_we0) wq0.push_back({mem_addr0, mem_wdata0});
    if (mem_we1) wq1.push_back({mem_addr1, mem_wdata1});
    if (out_valid0 && out_ready) oq0.push_back(out_data0);
    if (out_valid1 && out_ready) oq1.push_back(out_data1);
    if (seq_done0) done_pulses++;
  endtask

  task automatic advance();
    @(posedge clk);
    if (pend_we0) mem0[pend_a0] = pend_d0;
    if (pend_we1) mem1[pend_a1] = pend_d1;
    pend_we0 = 1'b0;
    pend_we1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    wq0.delete(); wq1.delete(); oq0.delete(); oq1.delete();
  endtask

  // From IDLE: accept go, stream LEN bytes back to back, pass START; ends at the first RUN cycle.
  task automatic go_and_load();
    go = 1'b1; in_valid = 1'b0; settle(); advance();
    go = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      in_data = 8'($urandom); settle(); advance();
    end
    in_valid = 1'b0; settle(); advance();
  endtask

  task automatic drain_all(input string name);
    int n;
    logic seen;
    n = 0; seen = 1'b0;
    out_ready = 1'b1;
    while (!seen && n < 50) begin
      settle();
      seen = seq_done0;
      advance();
      n++;
    end
    check({name, "_drain_bound"}, seen, 1'b1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b [LEN];
    logic [7:0]  r [LEN];
    logic [15:0] exp_w;
    logic [15:0] act_w;
    logic [7:0]  act_o;
    logic        stale, wrote, finished;
    int          wait_n, got, cyc, pulses0, n;

    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    pend_we0 = 1'b0; pend_we1 = 1'b0;
    pend_a0 = '0; pend_d0 = '0; pend_a1 = '0; pend_d1 = '0;
    reset = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = '0; core_done = 1'b0; out_ready = 1'b0;

    // ---- reset values
    #2;
    check("rst_busy", busy0, 1'b0);
    check("rst_core_start", core_start0, 1'b1);
    check("rst_mem_own", mem_own0, 1'b0);
    check("rst_in_ready", in_ready0, 1'b0);
    check("rst_mem_we", mem_we0, 1'b0);
    check("rst_mem_re", mem_re0, 1'b0);
    check("rst_mem_addr", mem_addr0, 8'h00);
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_out_data", out_data0, 8'h00);
    check("rst_seq_done", seq_done0, 1'b0);
`ifdef CORE_HOST_TIMEOUT_EN
    check("rst_timeout", timeout0, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // ---- cycle table: load with a valid gap, stale done, stalled drain, finish
    for (int i = 0; i < LEN; i++) begin
      mem0[64 + i] = 8'hA0 + 8'(i);
      mem1[64 + i] = 8'hA0 + 8'(i);
    end
    //   go iv id    cd ordy | busy own cs ir we addr  ov od     sd
    row(1, 0, 8'h00, 0, 0,     0,   0,  1, 0, 0, 8'h00, 0, 8'h00, 0); // IDLE, go
    row(0, 1, 8'h11, 0, 0,     1,   1,  1, 1, 1, 8'h00, 0, 8'h00, 0); // LOAD
    row(0, 0, 8'hEE, 0, 0,     1,   1,  1, 1, 0, 8'h01, 0, 8'h00, 0); // valid gap
    row(0, 1, 8'h22, 0, 0,     1,   1,  1, 1, 1, 8'h01, 0, 8'h00, 0);
    row(1, 1, 8'h33, 0, 0,     1,   1,  1, 1, 1, 8'h02, 0, 8'h00, 0); // go ignored
    row(0, 1, 8'h44, 1, 0,     1,   1,  1, 1, 1, 8'h03, 0, 8'h00, 0);
    row(0, 1, 8'h55, 1, 0,     1,   0,  1, 0, 0, 8'h00, 0, 8'h00, 0); // START
    row(0, 0, 8'h00, 1, 0,     1,   0,  0, 0, 0, 8'h00, 0, 8'h00, 0); // RUN 1, stale done
    row(1, 0, 8'h00, 0, 1,     1,   0,  0, 0, 0, 8'h00, 0, 8'h00, 0); // RUN 2, no done
    row(0, 0, 8'h00, 1, 0,     1,   0,  0, 0, 0, 8'h00, 0, 8'h00, 0); // RUN 3, done
    row(0, 0, 8'h00, 0, 0,     1,   1,  0, 0, 0, 8'h40, 1, 8'hA0, 0); // DRAIN stalled
    row(0, 1, 8'h66, 0, 0,     1,   1,  0, 0, 0, 8'h40, 1, 8'hA0, 0);
    row(0, 0, 8'h00, 1, 0,     1,   1,  0, 0, 0, 8'h40, 1, 8'hA0, 0);
    row(0, 0, 8'h00, 0, 1,     1,   1,  0, 0, 0, 8'h40, 1, 8'hA0, 0);
    row(0, 0, 8'h00, 0, 1,     1,   1,  0, 0, 0, 8'h41, 1, 8'hA1, 0);
    row(0, 0, 8'h00, 0, 1,     1,   1,  0, 0, 0, 8'h42, 1, 8'hA2, 0);
    row(0, 0, 8'h00, 0, 1,     1,   1,  0, 0, 0, 8'h43, 1, 8'hA3, 0);
    row(0, 0, 8'h00, 0, 0,     1,   0,  2, 0, 0, 8'h00, 0, 8'h00, 1); // FINISH
    row(0, 0, 8'h00, 0, 0,     0,   0,  1, 0, 0, 8'h00, 0, 8'h00, 0); // IDLE

    clear_logs();
    for (int i = 0; i < tbl.size(); i++) begin
      go = tbl[i].go; in_valid = tbl[i].iv; in_data = tbl[i].id;
      core_done = tbl[i].cd; out_ready = tbl[i].ordy;
      settle();
      check($sformatf("t%0d_busy", i), busy0, tbl[i].busy);
      check($sformatf("t%0d_mem_own", i), mem_own0, tbl[i].own);
      if (tbl[i].cs != 2) check($sformatf("t%0d_core_start", i), core_start0, 32'(tbl[i].cs));
      check($sformatf("t%0d_in_ready", i), in_ready0, tbl[i].ir);
      check($sformatf("t%0d_mem_we", i), mem_we0, tbl[i].we);
      check($sformatf("t%0d_mem_addr", i), mem_addr0, tbl[i].addr);
      check($sformatf("t%0d_out_valid", i), out_valid0, tbl[i].ov);
      check($sformatf("t%0d_mem_re", i), mem_re0, tbl[i].ov);
      check($sformatf("t%0d_out_data", i), out_data0, tbl[i].od);
      check($sformatf("t%0d_seq_done", i), seq_done0, tbl[i].sd);
      advance();
    end
    go = 1'b0; in_valid = 1'b0; core_done = 1'b0; out_ready = 1'b0;

    check("tbl_writes0_n", wq0.size(), 4);
    check("tbl_writes1_n", wq1.size(), 4);
    for (int i = 0; i < LEN; i++) begin
      exp_w = {8'(i), 8'h11 * 8'(i + 1)};
      act_w = (i < wq0.size()) ? wq0[i] : 16'hFFFF;
      check($sformatf("tbl_write0_%0d", i), act_w, exp_w);
      exp_w = {8'(254 + i), 8'h11 * 8'(i + 1)};
      act_w = (i < wq1.size()) ? wq1[i] : 16'hFFFF;
      check($sformatf("tbl_write1_wrap_%0d", i), act_w, exp_w);
      check($sformatf("tbl_mem0_%0d", i), mem0[i], 8'h11 * 8'(i + 1));
      act_o = (i < oq1.size()) ? oq1[i] : 8'hFF;
      check($sformatf("tbl_out1_%0d", i), act_o, 8'hA0 + 8'(i));
    end
    check("tbl_outs0_n", oq0.size(), 4);
    check("tbl_seq_done_pulses", done_pulses, 1);

    // ---- randomized sequences against a transaction-level model
    for (int s = 0; s < 8; s++) begin
      clear_logs();
      for (int i = 0; i < LEN; i++) begin
        b[i] = 8'($urandom);
        r[i] = 8'($urandom);
      end
      stale = 1'($urandom_range(0, 1));
      wait_n = $urandom_range(0, 4);
      wrote = 1'b0; got = 0; cyc = 0; finished = 1'b0;
      pulses0 = done_pulses;

      go = 1'b1; in_valid = 1'b0; core_done = stale; out_ready = 1'b0;
      settle(); advance();
      while (!finished && cyc < 300) begin
        go = ($urandom_range(0, 7) == 0);
        in_valid = ($urandom_range(0, 2) != 0);
        in_data = (got < LEN) ? b[got] : 8'($urandom);
        if (core_start0) begin
          core_done = stale;
        end else if (wait_n > 0) begin
          core_done = 1'b0;
          wait_n--;
        end else begin
          if (!wrote) begin
            for (int i = 0; i < LEN; i++) begin
              mem0[64 + i] = r[i];
              mem1[64 + i] = r[i];
            end
            wrote = 1'b1;
          end
          core_done = 1'b1;
        end
        out_ready = 1'($urandom_range(0, 1));
        settle();
        if (in_valid && in_ready0) got++;
        if (seq_done0) finished = 1'b1;
        advance();
        cyc++;
      end
      go = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

      check($sformatf("r%0d_finished", s), finished, 1'b1);
      check($sformatf("r%0d_pulses", s), done_pulses - pulses0, 1);
      check($sformatf("r%0d_writes_n", s), wq0.size() + wq1.size(), 2 * LEN);
      check($sformatf("r%0d_outs_n", s), oq0.size() + oq1.size(), 2 * LEN);
      for (int i = 0; i < LEN; i++) begin
        act_w = (i < wq0.size()) ? wq0[i] : 16'hFFFF;
        check($sformatf("r%0d_w0_%0d", s, i), act_w, {8'(i), b[i]});
        act_w = (i < wq1.size()) ? wq1[i] : 16'hFFFF;
        check($sformatf("r%0d_w1_%0d", s, i), act_w, {8'(254 + i), b[i]});
        act_o = (i < oq0.size()) ? oq0[i] : ~r[i];
        check($sformatf("r%0d_o0_%0d", s, i), act_o, r[i]);
        act_o = (i < oq1.size()) ? oq1[i] : ~r[i];
        check($sformatf("r%0d_o1_%0d", s, i), act_o, r[i]);
      end
      settle();
      check($sformatf("r%0d_idle_busy", s), busy0, 1'b0);
      check($sformatf("r%0d_idle_core_start", s), core_start0, 1'b1);
      advance();
    end
    core_done = 1'b0;

    // ---- reset asserted in DRAIN aborts at once
    core_done = 1'b1;
    go_and_load();
    settle(); advance();
    settle(); advance();
    core_done = 1'b0;
    out_ready = 1'b0;
    settle();
    check("abort_pre_out_valid", out_valid0, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_core_start", core_start0, 1'b1);
    check("abort_out_valid", out_valid0, 1'b0);
    check("abort_busy", busy0, 1'b0);
    check("abort_mem_own", mem_own0, 1'b0);
    check("abort_mem_re", mem_re0, 1'b0);
    check("abort_mem_addr", mem_addr0, 8'h00);
    #2;
    reset = 1'b0;
    advance();
    go = 1'b1;
    settle();
    check("abort_idle_go_busy", busy0, 1'b0);
    advance();
    go = 1'b0;
    settle();
    check("abort_restart_in_ready", in_ready0, 1'b1);
    advance();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(negedge clk);

`ifdef CORE_HOST_TIMEOUT_EN
    // ---- watchdog: done never rises
    core_done = 1'b0;
    go_and_load();
    n = 0;
    settle();
    while (!out_valid0 && n < 40) begin
      if (busy0 && !core_start0 && !mem_own0) n++;
      advance();
      settle();
    end
    check("to_run_cycles", n, 10);
    check("to_flag_set", timeout0, 1'b1);
    advance();
    drain_all("to");
    settle();
    check("to_flag_sticky_idle", timeout0, 1'b1);
    advance();

    // ---- done arriving on the limit cycle wins
    go_and_load();
    for (int i = 1; i < 10; i++) begin
      settle(); advance();
    end
    core_done = 1'b1;
    settle();
    check("to_cleared_by_go", timeout0, 1'b0);
    advance();
    core_done = 1'b0;
    settle();
    check("to_done_wins_drain", out_valid0, 1'b1);
    check("to_done_wins_flag", timeout0, 1'b0);
    advance();
    drain_all("to_done_wins");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
